// File: rtl/execute_pkg.sv
// Shared decode constants, ALU operation encoding and RV32I immediate extraction
// for the integer execute stage.
package execute_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_e;

    function automatic logic [31:0] imm_i(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[31:20]};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ins);
        return {ins[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

    // funct7[5] only means SUB on register-register ops; ADDI has no subtract form.
    function automatic alu_op_e decode_alu(input logic [2:0] f3, input logic f7b5,
                                           input logic is_reg);
        alu_op_e op;
        case (f3)
            F3_ADD:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = f7b5 ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/execute_alu.sv
// Combinational 32-bit integer ALU; shift amount is taken from b[4:0].
module execute_alu
    import execute_pkg::*;
(
    input  alu_op_e     op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o
);

    logic [4:0] shamt;
    assign shamt = b_i[4:0];

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SLT:  result_o = {31'b0, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {31'b0, a_i < b_i};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/execute.sv
// RV32I integer execute stage: ALU/LUI/AUIPC/link results plus branch and jump
// resolution, with a registered report and a combinational early redirect.
module execute
    import execute_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic [31:0] opcode_pc_i,
    input  logic        opcode_invalid_i,
    input  logic [4:0]  opcode_rd_idx_i,
    input  logic [4:0]  opcode_ra_idx_i,
    input  logic [4:0]  opcode_rb_idx_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
    input  logic        hold_i,
    output logic        branch_request_o,
    output logic        branch_is_taken_o,
    output logic        branch_is_not_taken_o,
    output logic [31:0] branch_source_o,
    output logic        branch_is_call_o,
    output logic        branch_is_ret_o,
    output logic        branch_is_jmp_o,
    output logic [31:0] branch_pc_o,
    output logic        branch_d_request_o,
    output logic [31:0] branch_d_pc_o,
    output logic [1:0]  branch_d_priv_o,
    output logic [31:0] writeback_value_o
);

    logic [31:0] ins, pc, ra, rb;
    logic [6:0]  opc;
    logic [2:0]  funct3;
    logic        unused_rb_idx;

    assign ins    = opcode_opcode_i;
    assign pc     = opcode_pc_i;
    assign ra     = opcode_ra_operand_i;
    assign rb     = opcode_rb_operand_i;
    assign opc    = ins[6:0];
    assign funct3 = ins[14:12];
    // Source indices are only needed for the return-detection rule on rs1.
    assign unused_rb_idx = ^opcode_rb_idx_i;

    alu_op_e     alu_op;
    logic [31:0] alu_a, alu_b, alu_result;

    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = '0;
        alu_b  = '0;
        case (opc)
            OPC_OP: begin
                alu_op = decode_alu(funct3, ins[30], 1'b1);
                alu_a  = ra;
                alu_b  = rb;
            end
            OPC_OPIMM: begin
                alu_op = decode_alu(funct3, ins[30], 1'b0);
                alu_a  = ra;
                alu_b  = imm_i(ins);
            end
            OPC_LUI: alu_b = imm_u(ins);
            OPC_AUIPC: begin
                alu_a = pc;
                alu_b = imm_u(ins);
            end
            OPC_JAL, OPC_JALR: begin
                alu_a = pc;
                alu_b = 32'd4;
            end
            default: ;
        endcase
    end

    execute_alu u_alu (
        .op_i     (alu_op),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .result_o (alu_result)
    );

    logic        is_br, is_jal, is_jalr, is_jump, active, cond;
    logic        taken_d, not_taken_d, call_d, ret_d, jmp_d;
    logic [31:0] target, pc_plus4, next_pc, source_d, pc_d;

    assign is_br    = (opc == OPC_BRANCH);
    assign is_jal   = (opc == OPC_JAL);
    assign is_jalr  = (opc == OPC_JALR);
    assign is_jump  = is_jal | is_jalr;
    assign active   = opcode_valid_i & ~opcode_invalid_i & (is_br | is_jump);
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = (ra == rb);
            F3_BNE:  cond = (ra != rb);
            F3_BLT:  cond = ($signed(ra) < $signed(rb));
            F3_BGE:  cond = ($signed(ra) >= $signed(rb));
            F3_BLTU: cond = (ra < rb);
            F3_BGEU: cond = (ra >= rb);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        target = pc + imm_b(ins);
        if (is_jal)
            target = pc + imm_j(ins);
        else if (is_jalr)
            target = (ra + imm_i(ins)) & ~32'd1;
    end

    assign taken_d     = active & (is_jump | cond);
    assign not_taken_d = active & is_br & ~cond;
    assign call_d      = active & is_jump & (opcode_rd_idx_i == 5'd1);
    assign ret_d       = active & is_jalr & (opcode_ra_idx_i == 5'd1)
                       & (imm_i(ins) == 32'd0) & (opcode_rd_idx_i == 5'd0);
    assign jmp_d       = active & is_jump & ~call_d & ~ret_d;
    assign next_pc     = taken_d ? target : pc_plus4;
    assign source_d    = active ? pc : '0;
    assign pc_d        = active ? next_pc : '0;

    assign branch_d_request_o = taken_d;
    assign branch_d_pc_o      = next_pc;
    assign branch_d_priv_o    = 2'b11;

    logic        taken_q, not_taken_q, call_q, ret_q, jmp_q;
    logic [31:0] source_q, pc_q, wb_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            taken_q     <= 1'b0;
            not_taken_q <= 1'b0;
            call_q      <= 1'b0;
            ret_q       <= 1'b0;
            jmp_q       <= 1'b0;
            source_q    <= '0;
            pc_q        <= '0;
            wb_q        <= '0;
        end else if (!hold_i) begin
            taken_q     <= taken_d;
            not_taken_q <= not_taken_d;
            call_q      <= call_d;
            ret_q       <= ret_d;
            jmp_q       <= jmp_d;
            source_q    <= source_d;
            pc_q        <= pc_d;
            wb_q        <= alu_result;
        end
    end

    assign branch_request_o      = taken_q | not_taken_q;
    assign branch_is_taken_o     = taken_q;
    assign branch_is_not_taken_o = not_taken_q;
    assign branch_source_o       = source_q;
    assign branch_is_call_o      = call_q;
    assign branch_is_ret_o       = ret_q;
    assign branch_is_jmp_o       = jmp_q;
    assign branch_pc_o           = pc_q;
    assign writeback_value_o     = wb_q;

endmodule

// File: tb/tb_execute.sv
// Directed bench for the execute stage: ALU results, jumps, branches, gating,
// hold and asynchronous reset, each compared against hand-computed values.
module tb_execute;

    logic        clk;
    logic        rst_n;
    logic        valid, invalid, hold;
    logic [31:0] ins, pc, ra, rb;
    logic [4:0]  rd_idx, ra_idx, rb_idx;

    logic        br_req, br_tk, br_ntk, br_call, br_ret, br_jmp, d_req;
    logic [31:0] br_src, br_pc, d_pc, wb;
    logic [1:0]  d_priv;

    int checks;
    int failures;

    execute dut (
        .clk_i                 (clk),
        .rst_i                 (rst_n),
        .opcode_valid_i        (valid),
        .opcode_opcode_i       (ins),
        .opcode_pc_i           (pc),
        .opcode_invalid_i      (invalid),
        .opcode_rd_idx_i       (rd_idx),
        .opcode_ra_idx_i       (ra_idx),
        .opcode_rb_idx_i       (rb_idx),
        .opcode_ra_operand_i   (ra),
        .opcode_rb_operand_i   (rb),
        .hold_i                (hold),
        .branch_request_o      (br_req),
        .branch_is_taken_o     (br_tk),
        .branch_is_not_taken_o (br_ntk),
        .branch_source_o       (br_src),
        .branch_is_call_o      (br_call),
        .branch_is_ret_o       (br_ret),
        .branch_is_jmp_o       (br_jmp),
        .branch_pc_o           (br_pc),
        .branch_d_request_o    (d_req),
        .branch_d_pc_o         (d_pc),
        .branch_d_priv_o       (d_priv),
        .writeback_value_o     (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_br(input string tag, input logic req, input logic tk, input logic ntk,
                          input logic [31:0] src, input logic call, input logic ret,
                          input logic jmp, input logic [31:0] tpc);
        chk({tag, ".req"},  {31'b0, br_req},  {31'b0, req});
        chk({tag, ".tk"},   {31'b0, br_tk},   {31'b0, tk});
        chk({tag, ".ntk"},  {31'b0, br_ntk},  {31'b0, ntk});
        chk({tag, ".src"},  br_src, src);
        chk({tag, ".call"}, {31'b0, br_call}, {31'b0, call});
        chk({tag, ".ret"},  {31'b0, br_ret},  {31'b0, ret});
        chk({tag, ".jmp"},  {31'b0, br_jmp},  {31'b0, jmp});
        chk({tag, ".pc"},   br_pc, tpc);
    endtask

    task automatic drive(input logic [31:0] i_ins, input logic [31:0] i_pc,
                         input logic [31:0] i_ra, input logic [31:0] i_rb,
                         input logic [4:0] i_rd, input logic [4:0] i_ra_idx);
        valid   = 1'b1;
        invalid = 1'b0;
        ins     = i_ins;
        pc      = i_pc;
        ra      = i_ra;
        rb      = i_rb;
        rd_idx  = i_rd;
        ra_idx  = i_ra_idx;
        rb_idx  = 5'd2;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        hold     = 1'b0;
        valid    = 1'b0;
        invalid  = 1'b0;
        ins      = '0;
        pc       = '0;
        ra       = '0;
        rb       = '0;
        rd_idx   = '0;
        ra_idx   = '0;
        rb_idx   = '0;
        #2;
        chk("reset.wb", wb, 32'h0);
        chk_br("reset", 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        chk("priv", {30'b0, d_priv}, 32'h3);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Register and immediate ALU forms
        drive(32'h00000033, 32'h100, 32'd5, 32'd3, 5'd3, 5'd4); step();
        chk("add", wb, 32'd8);
        chk_br("add", 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        drive(32'h40000033, 32'h104, 32'd8, 32'd3, 5'd3, 5'd4); step();
        chk("sub", wb, 32'd5);
        drive(32'h40005033, 32'h108, 32'h80000008, 32'd2, 5'd3, 5'd4); step();
        chk("sra", wb, 32'hE0000002);
        drive(32'h00005033, 32'h10C, 32'h80000008, 32'd2, 5'd3, 5'd4); step();
        chk("srl", wb, 32'h20000002);
        drive(32'h00002033, 32'h110, 32'hFFFFFFF0, 32'h10, 5'd3, 5'd4); step();
        chk("slt", wb, 32'd1);
        drive(32'h00003033, 32'h114, 32'hFFFFFFF0, 32'h10, 5'd3, 5'd4); step();
        chk("sltu", wb, 32'd0);
        drive(32'h00500013, 32'h118, 32'd3, 32'h55, 5'd3, 5'd4); step();
        chk("addi", wb, 32'd8);
        drive(32'h00507013, 32'h11C, 32'hF, 32'h55, 5'd3, 5'd4); step();
        chk("andi", wb, 32'd5);
        drive(32'h00001037, 32'h120, 32'h77, 32'h55, 5'd3, 5'd4); step();
        chk("lui", wb, 32'h1000);
        drive(32'h00001017, 32'h1000, 32'h77, 32'h55, 5'd3, 5'd4); step();
        chk("auipc", wb, 32'h2000);

        // Jumps
        drive(32'h0040006F, 32'h1000, 32'h0, 32'h0, 5'd1, 5'd0);
        chk("jal.dreq", {31'b0, d_req}, 32'd1);
        chk("jal.dpc", d_pc, 32'h1004);
        step();
        chk_br("jal", 1, 1, 0, 32'h1000, 1, 0, 0, 32'h1004);
        chk("jal.wb", wb, 32'h1004);
        drive(32'h00008067, 32'h3000, 32'h2000, 32'h0, 5'd0, 5'd1);
        chk("jalr.dpc", d_pc, 32'h2000);
        step();
        chk_br("jalr", 1, 1, 0, 32'h3000, 0, 1, 0, 32'h2000);
        chk("jalr.wb", wb, 32'h3004);
        drive(32'h0040006F, 32'h1000, 32'h0, 32'h0, 5'd0, 5'd0); step();
        chk_br("jaljmp", 1, 1, 0, 32'h1000, 0, 0, 1, 32'h1004);

        // Conditional branches
        drive(32'h00000463, 32'h2000, 32'd5, 32'd5, 5'd0, 5'd1);
        chk("beq.dreq", {31'b0, d_req}, 32'd1);
        chk("beq.dpc", d_pc, 32'h2008);
        step();
        chk_br("beq", 1, 1, 0, 32'h2000, 0, 0, 0, 32'h2008);
        chk("beq.wb", wb, 32'h0);
        drive(32'h00001463, 32'h2000, 32'd5, 32'd5, 5'd0, 5'd1);
        chk("bne.dreq", {31'b0, d_req}, 32'd0);
        step();
        chk_br("bne", 1, 0, 1, 32'h2000, 0, 0, 0, 32'h2004);
        drive(32'h00004463, 32'h2000, 32'hFFFFFFF0, 32'h10, 5'd0, 5'd1); step();
        chk_br("blt", 1, 1, 0, 32'h2000, 0, 0, 0, 32'h2008);
        drive(32'h00006463, 32'h2000, 32'hFFFFFFF0, 32'h10, 5'd0, 5'd1); step();
        chk_br("bltu", 1, 0, 1, 32'h2000, 0, 0, 0, 32'h2004);
        drive(32'h00005463, 32'h2000, 32'd5, 32'd5, 5'd0, 5'd1); step();
        chk_br("bge", 1, 1, 0, 32'h2000, 0, 0, 0, 32'h2008);
        drive(32'h00007463, 32'h2000, 32'h10, 32'hFFFFFFF0, 5'd0, 5'd1); step();
        chk_br("bgeu", 1, 0, 1, 32'h2000, 0, 0, 0, 32'h2004);
        drive(32'h00002463, 32'h2000, 32'd5, 32'd5, 5'd0, 5'd1); step();
        chk_br("f3_010", 1, 0, 1, 32'h2000, 0, 0, 0, 32'h2004);
        drive(32'hFE000CE3, 32'h2000, 32'd5, 32'd5, 5'd0, 5'd1); step();
        chk_br("beqneg", 1, 1, 0, 32'h2000, 0, 0, 0, 32'h1FF8);

        // Gating by valid and invalid, each after a taken branch
        drive(32'h00000463, 32'h2000, 32'd5, 32'd5, 5'd0, 5'd1); step();
        valid = 1'b0;
        #1;
        chk("novalid.dreq", {31'b0, d_req}, 32'd0);
        step();
        chk_br("novalid", 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        drive(32'h0040006F, 32'h1000, 32'h0, 32'h0, 5'd1, 5'd0); step();
        drive(32'h00000463, 32'h2000, 32'd5, 32'd5, 5'd0, 5'd1);
        invalid = 1'b1;
        #1;
        chk("invalid.dreq", {31'b0, d_req}, 32'd0);
        step();
        chk_br("invalid", 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        invalid = 1'b0;

        // Hold freezes registered state but not the early redirect
        drive(32'h0040006F, 32'h1000, 32'h0, 32'h0, 5'd1, 5'd0); step();
        hold = 1'b1;
        drive(32'h00000463, 32'h4000, 32'd5, 32'd5, 5'd0, 5'd1);
        chk("hold.dreq", {31'b0, d_req}, 32'd1);
        chk("hold.dpc", d_pc, 32'h4008);
        step();
        step();
        chk_br("hold", 1, 1, 0, 32'h1000, 1, 0, 0, 32'h1004);
        chk("hold.wb", wb, 32'h1004);
        hold = 1'b0;
        step();
        chk_br("unhold", 1, 1, 0, 32'h4000, 0, 0, 0, 32'h4008);
        chk("unhold.wb", wb, 32'h0);

        // Asynchronous reset between clock edges
        drive(32'h0040006F, 32'h1000, 32'h0, 32'h0, 5'd1, 5'd0); step();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst.wb", wb, 32'h0);
        chk_br("arst", 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
        step();
        chk("arst_hold.wb", wb, 32'h0);
        rst_n = 1'b1;
        step();
        chk("post_rst.wb", wb, 32'h1004);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
